// File: rtl/snes_pad_responder.sv
// SNES pad emulator: conditions the host's latch/clock strobes, snapshots the
// 12 buttons on latch, and shifts the frame out active-low on serial_data.
module snes_pad_responder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 2,
    parameter int NUM_BITS      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_latch,
    input  logic        data_clock,
    input  logic [11:0] buttons,
    output logic        serial_data,
    output logic        frame_done,
    output logic        busy,
    output logic [4:0]  bit_index
);

    localparam int CW = 4;
    // Index 0 is the latch strobe (idles low), index 1 the shift clock (idles high).
    localparam logic [1:0] IDLE_LVL = 2'b10;
    localparam logic [4:0] LAST_IDX = 5'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    logic [1:0] strobe_pin;
    logic [1:0] filt;
    logic [1:0] filt_prev;

    assign strobe_pin = {data_clock, data_latch};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CW-1:0]          cnt_q;
            logic                   filt_q;
            logic                   prev_q;

            // Synchronize, then only accept a level once it has held long enough.
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_q <= {SYNC_STAGES{IDLE_LVL[gi]}};
                    cnt_q  <= '0;
                    filt_q <= IDLE_LVL[gi];
                    prev_q <= IDLE_LVL[gi];
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_pin[gi]};
                    prev_q <= filt_q;
                    if (sync_q[SYNC_STAGES-1] == filt_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= CW'(FILTER_CYCLES - 1)) begin
                        cnt_q  <= CW'(FILTER_CYCLES);
                        filt_q <= ~filt_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign filt[gi]      = filt_q;
            assign filt_prev[gi] = prev_q;
        end
    endgenerate

    logic latch_rise;
    logic latch_fall;
    logic clk_rise;

    assign latch_rise = filt[0] & ~filt_prev[0];
    assign latch_fall = ~filt[0] & filt_prev[0];
    assign clk_rise   = filt[1] & ~filt_prev[1];

    // Pressed buttons read as 0 on the line; ID bits above the buttons read high.
    logic [NUM_BITS-1:0] load_word;
    assign load_word = {{(NUM_BITS - 12){1'b1}}, ~buttons};

    state_t              state_q;
    logic [NUM_BITS-1:0] shift_q;
    logic                serial_q;
    logic                frame_done_q;
    logic                busy_q;
    logic [4:0]          bit_index_q;

    // Frame sequencer; a new latch always restarts the frame from any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '1;
            serial_q     <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_index_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (latch_rise) begin
                state_q     <= ST_LATCH;
                shift_q     <= load_word;
                serial_q    <= load_word[0];
                busy_q      <= 1'b1;
                bit_index_q <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        serial_q    <= 1'b1;
                        bit_index_q <= '0;
                    end
                    ST_LATCH: begin
                        // Track the buttons until the latch drops.
                        shift_q  <= load_word;
                        serial_q <= load_word[0];
                        if (latch_fall) begin
                            state_q     <= ST_SHIFT;
                            bit_index_q <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            shift_q     <= {1'b0, shift_q[NUM_BITS-1:1]};
                            bit_index_q <= bit_index_q + 1'b1;
                            if (bit_index_q == LAST_IDX) begin
                                state_q      <= ST_DONE;
                                serial_q     <= 1'b0;
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                            end else begin
                                serial_q <= shift_q[1];
                            end
                        end
                    end
                    ST_DONE: begin
                        serial_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign serial_data = serial_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign bit_index   = bit_index_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Host-side model driving latch/clock strobes into the pad responder and
// checking the line bits it returns against a queue of expected bits.
module tb_snes_pad_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        data_latch;
    logic        data_clock;
    logic [11:0] buttons;
    logic        serial_data;
    logic        frame_done;
    logic        busy;
    logic [4:0]  bit_index;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;
    int bits_shifted = 0;
    logic exp_q[$];

    snes_pad_responder dut (
        .clock       (clock),
        .reset       (reset),
        .data_latch  (data_latch),
        .data_clock  (data_clock),
        .buttons     (buttons),
        .serial_data (serial_data),
        .frame_done  (frame_done),
        .busy        (busy),
        .bit_index   (bit_index)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Latch a button snapshot and queue the bits the host should read back.
    task automatic start_frame(input logic [11:0] btn, input int extra);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(i < 12 ? ~btn[i] : 1'b1);
        for (int i = 0; i < extra; i++) exp_q.push_back(1'b0);
        bits_shifted = 0;
        buttons = btn;
        data_latch = 1'b1;
        repeat (12) tick();
        data_latch = 1'b0;
        repeat (8) tick();
        $display("frame latched buttons=%03h", btn);
    endtask

    // Clock n bits out, sampling the line at the end of each low phase.
    task automatic shift_bits(input int n, input logic [11:0] mid_btn, input int mid_at);
        logic exp_bit;
        int   exp_idx;
        for (int i = 0; i < n; i++) begin
            data_clock = 1'b0;
            repeat (8) tick();
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: bit %0d sampled %b but nothing expected", bits_shifted, serial_data);
            end else begin
                exp_bit = exp_q.pop_front();
                if (serial_data !== exp_bit)
                    $display("FAIL line_bit[%0d]: got %b expected %b", bits_shifted, serial_data, exp_bit);
                else n_pass++;
            end
            if (i == mid_at) buttons = mid_btn;
            data_clock = 1'b1;
            bits_shifted++;
            if (bits_shifted == 16) begin
                for (int c = 1; c <= 8; c++) begin
                    tick();
                    n_checks++;
                    if (frame_done !== (c == 5))
                        $display("FAIL frame_done_cycle[%0d]: got %b expected %b", c, frame_done, (c == 5));
                    else n_pass++;
                end
            end else begin
                repeat (8) tick();
            end
            exp_idx = (bits_shifted > 16) ? 16 : bits_shifted;
            n_checks++;
            if (bit_index !== 5'(exp_idx))
                $display("FAIL bit_index_after_shift: got %0d expected %0d", bit_index, exp_idx);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        data_latch = 1'b0;
        data_clock = 1'b1;
        buttons = 12'h000;
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if ({serial_data, busy, frame_done, bit_index} !== {1'b1, 1'b0, 1'b0, 5'd0})
                $display("FAIL idle_outputs[%0d]: got sd=%b busy=%b fd=%b idx=%0d expected sd=1 busy=0 fd=0 idx=0",
                         c, serial_data, busy, frame_done, bit_index);
            else n_pass++;
        end
        $display("reset/idle done");
    endtask

    task automatic test_glitch;
        data_latch = 1'b1;
        tick();
        data_latch = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if ({busy, serial_data} !== 2'b01)
                $display("FAIL glitch_ignored[%0d]: got busy=%b sd=%b expected busy=0 sd=1", c, busy, serial_data);
            else n_pass++;
        end
        $display("short latch pulse done");
    endtask

    task automatic test_frame_b;
        int fd_before;
        fd_before = fd_count;
        start_frame(12'h001, 1);
        n_checks++;
        if ({busy, bit_index} !== {1'b1, 5'd0})
            $display("FAIL shift_ready: got busy=%b idx=%0d expected busy=1 idx=0", busy, bit_index);
        else n_pass++;
        shift_bits(17, 12'h001, -1);
        n_checks++;
        if (fd_count - fd_before !== 1)
            $display("FAIL frame_b_done_count: got %0d expected 1", fd_count - fd_before);
        else n_pass++;
        n_checks++;
        if ({serial_data, busy} !== 2'b00)
            $display("FAIL after_frame: got sd=%b busy=%b expected sd=0 busy=0", serial_data, busy);
        else n_pass++;
        $display("frame B-only done");
    endtask

    task automatic test_frame_a5a;
        start_frame(12'hA5A, 0);
        shift_bits(16, 12'hFFF, 4);
        $display("frame A5A with mid-shift button change done");
    endtask

    task automatic test_abort;
        int fd_before;
        fd_before = fd_count;
        start_frame(12'h3C5, 0);
        shift_bits(7, 12'h3C5, -1);
        start_frame(12'h6B9, 2);
        n_checks++;
        if ({busy, bit_index} !== {1'b1, 5'd0})
            $display("FAIL abort_restart: got busy=%b idx=%0d expected busy=1 idx=0", busy, bit_index);
        else n_pass++;
        n_checks++;
        if (fd_count !== fd_before)
            $display("FAIL abort_no_done: got %0d pulses expected 0", fd_count - fd_before);
        else n_pass++;
        shift_bits(18, 12'h6B9, -1);
        n_checks++;
        if (fd_count - fd_before !== 1)
            $display("FAIL abort_done_count: got %0d expected 1", fd_count - fd_before);
        else n_pass++;
        $display("abort and restart done");
    endtask

    task automatic test_reset_mid_frame;
        start_frame(12'h3C3, 0);
        shift_bits(9, 12'h3C3, -1);
        n_checks++;
        if (bit_index !== 5'd9)
            $display("FAIL pre_reset_index: got %0d expected 9", bit_index);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({serial_data, frame_done, busy, bit_index} !== {1'b1, 1'b0, 1'b0, 5'd0})
            $display("FAIL mid_reset_outputs: got sd=%b fd=%b busy=%b idx=%0d expected sd=1 fd=0 busy=0 idx=0",
                     serial_data, frame_done, busy, bit_index);
        else n_pass++;
        exp_q.delete();
        data_clock = 1'b0;
        repeat (8) tick();
        data_clock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({serial_data, busy, bit_index} !== {1'b1, 1'b0, 5'd0})
                $display("FAIL clk_after_reset[%0d]: got sd=%b busy=%b idx=%0d expected sd=1 busy=0 idx=0",
                         c, serial_data, busy, bit_index);
            else n_pass++;
        end
        $display("reset mid-frame done");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_frame_b();
        test_frame_a5a();
        test_abort();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
